// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams a contiguous (mod-8, wrapping) range of register
// file words out over a valid/ready interface, one word per two cycles.
// Optional feature: define REG_DUMP_CHECKSUM_EN to append one trailing word
// holding the XOR of all dumped words (that word then carries out_last).
module reg_dump_reader #(
    parameter int inst_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           cfg_first,
    input  logic [2:0]           cfg_last,
    output logic [2:0]           rf_addr,
    input  logic [inst_SIZE-1:0] rf_data,
    output logic [inst_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             end_q, end_d;
    logic [2:0]             rf_addr_q, rf_addr_d;
    logic [inst_SIZE-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [inst_SIZE-1:0]   csum_q, csum_d;
`endif
    logic                   hs;

    assign hs        = out_valid_q && out_ready;
    assign rf_addr   = rf_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    // Next-state and datapath updates; every register holds unless a state acts on it.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        end_d       = end_q;
        rf_addr_d   = rf_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d     = cfg_first;
                    end_d     = cfg_last;
                    rf_addr_d = cfg_first;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d    = '0;
`endif
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                // rf_addr has been stable for a full cycle, so rf_data is settled.
                out_data_d  = rf_data;
                out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_d      = csum_q ^ rf_data;
                out_last_d  = 1'b0;
`else
                out_last_d  = (idx_q == end_q);
`endif
                state_d     = SEND;
            end
            SEND: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (idx_q != end_q) begin
                        idx_d     = idx_q + 3'd1;
                        rf_addr_d = idx_q + 3'd1;
                        state_d   = FETCH;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // csum_q already includes the final data word.
                        out_data_d  = csum_q;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        state_d     = CSUM;
`else
                        state_d     = DONE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; active-low synchronous reset abandons any dump.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            end_q       <= 3'd0;
            rf_addr_q   <= 3'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            end_q       <= end_d;
            rf_addr_q   <= rf_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader (works with or without
// REG_DUMP_CHECKSUM_EN defined).
`timescale 1ns/1ps
module tb_reg_dump_reader;
    localparam int W = 16;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CSUM_EXTRA = 1;
`else
    localparam int CSUM_EXTRA = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   cfg_first;
    logic [2:0]   cfg_last;
    logic [2:0]   rf_addr;
    logic [W-1:0] rf_data;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         done;

    logic [W-1:0] regs [8];

    always #5 clk = ~clk;

    assign rf_data = regs[rf_addr];

    reg_dump_reader #(.inst_SIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_first (cfg_first),
        .cfg_last  (cfg_last),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [2:0]  f;
        logic [2:0]  l;
        int          stall;
        int          restart_at;
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_lastw;
    } vec_t;

    vec_t vecs [7];

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] got_data [$];
    logic         got_last [$];
    logic [2:0]   got_addr [$];
    int done_cnt, done_iter, last_hs_iter, first_valid_iter;
    int stable_err, busy_err, post_err;
    bit finished;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_word(input int i);
        if (i < got_data.size()) return {16'h0, got_data[i]};
        return 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] get_lastf(input int i);
        if (i < got_last.size()) return {31'h0, got_last[i]};
        return 32'd9;
    endfunction

    function automatic logic [31:0] get_addr(input int i);
        if (i < got_addr.size()) return {29'h0, got_addr[i]};
        return 32'd99;
    endfunction

    // Must be entered right after a falling edge. Drives one dump and records
    // every accepted word; out_ready is held low for 'stall' cycles of each word.
    task automatic run_dump(input logic [2:0] f, input logic [2:0] l,
                            input int stall, input int restart_at);
        int vcount;
        int cyc;
        logic [W-1:0] held_data;
        logic held_last;
        got_data.delete();
        got_last.delete();
        got_addr.delete();
        done_cnt = 0; done_iter = -1; last_hs_iter = -1; first_valid_iter = -1;
        stable_err = 0; busy_err = 0; post_err = 0; finished = 1'b0;
        vcount = 0; held_data = '0; held_last = 1'b0;
        cfg_first = f; cfg_last = l; start = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!finished && cyc < 200) begin
            start = (cyc == restart_at);
            cfg_first = start ? f + 3'd2 : f;
            cfg_last  = start ? f + 3'd3 : l;
            if (!busy) busy_err++;
            if (done) begin
                done_cnt++;
                done_iter = cyc;
                finished = 1'b1;
            end
            if (out_valid) begin
                if (first_valid_iter < 0) first_valid_iter = cyc;
                vcount++;
                if (vcount == 1) begin
                    held_data = out_data;
                    held_last = out_last;
                end else if (out_data !== held_data || out_last !== held_last) begin
                    stable_err++;
                end
                out_ready = (vcount > stall);
                if (out_ready) begin
                    got_data.push_back(out_data);
                    got_last.push_back(out_last);
                    got_addr.push_back(rf_addr);
                    last_hs_iter = cyc;
                    vcount = 0;
                end
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        cfg_first = f;
        cfg_last = l;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (done || out_valid || busy) post_err++;
            @(negedge clk);
        end
    endtask

    task automatic check_dump(input string tag, input logic [2:0] f, input logic [2:0] l,
                              input int exp_n, input logic [15:0] exp_first,
                              input logic [15:0] exp_lastw);
        int total;
        logic [15:0] csum;
        logic [15:0] w;
        total = exp_n + CSUM_EXTRA;
        check({tag, " finished"}, {31'h0, finished}, 32'd1);
        check({tag, " word count"}, got_data.size(), total);
        check({tag, " first word"}, get_word(0), {16'h0, exp_first});
        check({tag, " last data word"}, get_word(exp_n - 1), {16'h0, exp_lastw});
        csum = '0;
        for (int i = 0; i < total; i++) begin
            if (i < exp_n) begin
                w = 16'h1000 + 16'((int'(f) + i) % 8);
                csum = csum ^ w;
            end else begin
                w = csum;
            end
            check($sformatf("%s data[%0d]", tag, i), get_word(i), {16'h0, w});
            check($sformatf("%s last[%0d]", tag, i), get_lastf(i), {31'h0, (i == total - 1)});
        end
        for (int i = 0; i < exp_n; i++)
            check($sformatf("%s addr[%0d]", tag, i), get_addr(i), (int'(f) + i) % 8);
        check({tag, " first valid latency"}, first_valid_iter, 32'd1);
        check({tag, " done pulses"}, done_cnt, 32'd1);
        check({tag, " done after last handshake"}, done_iter, last_hs_iter + 1);
        check({tag, " data stable while stalled"}, stable_err, 32'd0);
        check({tag, " busy during dump"}, busy_err, 32'd0);
        check({tag, " quiet after done"}, post_err, 32'd0);
        check({tag, " end index"}, {29'h0, l}, (int'(f) + exp_n - 1) % 8);
    endtask

    initial begin
        logic [15:0] exp21 [4];
        logic [2:0]  adr21 [4];
        int sends;

        for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);

        vecs[0] = '{f: 3'd0, l: 3'd7, stall: 0, restart_at: -1, exp_n: 8, exp_first: 16'h1000, exp_lastw: 16'h1007};
        vecs[1] = '{f: 3'd6, l: 3'd1, stall: 0, restart_at: -1, exp_n: 4, exp_first: 16'h1006, exp_lastw: 16'h1001};
        vecs[2] = '{f: 3'd3, l: 3'd3, stall: 5, restart_at: -1, exp_n: 1, exp_first: 16'h1003, exp_lastw: 16'h1003};
        vecs[3] = '{f: 3'd2, l: 3'd5, stall: 1, restart_at: -1, exp_n: 4, exp_first: 16'h1002, exp_lastw: 16'h1005};
        vecs[4] = '{f: 3'd7, l: 3'd0, stall: 0, restart_at: -1, exp_n: 2, exp_first: 16'h1007, exp_lastw: 16'h1000};
        vecs[5] = '{f: 3'd5, l: 3'd4, stall: 0, restart_at: -1, exp_n: 8, exp_first: 16'h1005, exp_lastw: 16'h1004};
        vecs[6] = '{f: 3'd1, l: 3'd4, stall: 0, restart_at: 3,  exp_n: 4, exp_first: 16'h1001, exp_lastw: 16'h1004};

        rst = 1'b0; start = 1'b0; out_ready = 1'b0; cfg_first = 3'd0; cfg_last = 3'd0;
        repeat (3) @(negedge clk);
        check("reset rf_addr", {29'h0, rf_addr}, 32'd0);
        check("reset out_data", {16'h0, out_data}, 32'd0);
        check("reset out_valid", {31'h0, out_valid}, 32'd0);
        check("reset out_last", {31'h0, out_last}, 32'd0);
        check("reset busy", {31'h0, busy}, 32'd0);
        check("reset done", {31'h0, done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_dump(vecs[v].f, vecs[v].l, vecs[v].stall, vecs[v].restart_at);
            check_dump($sformatf("vec%0d", v), vecs[v].f, vecs[v].l, vecs[v].exp_n,
                       vecs[v].exp_first, vecs[v].exp_lastw);
        end

        // Wrapping range 6..1 checked against literal words and addresses,
        // then rf_addr must stay on the last index while idle.
        exp21 = '{16'h1006, 16'h1007, 16'h1000, 16'h1001};
        adr21 = '{3'd6, 3'd7, 3'd0, 3'd1};
        run_dump(3'd6, 3'd1, 0, -1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap word %0d", i), get_word(i), {16'h0, exp21[i]});
            check($sformatf("wrap addr %0d", i), get_addr(i), {29'h0, adr21[i]});
        end
        repeat (2) @(negedge clk);
        check("idle holds rf_addr", {29'h0, rf_addr}, 32'd1);

        // Reset asserted during the third SEND cycle of a full dump.
        cfg_first = 3'd0; cfg_last = 3'd7; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sends = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) sends++;
            if (sends == 3) break;
            @(negedge clk);
        end
        check("midreset reached 3rd send", sends, 32'd3);
        check("midreset 3rd word", {16'h0, out_data}, 32'h1002);
        rst = 1'b0;
        @(negedge clk);
        check("midreset out_valid", {31'h0, out_valid}, 32'd0);
        check("midreset busy", {31'h0, busy}, 32'd0);
        check("midreset out_last", {31'h0, out_last}, 32'd0);
        check("midreset rf_addr", {29'h0, rf_addr}, 32'd0);
        check("midreset out_data", {16'h0, out_data}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("after reset still idle", {31'h0, busy}, 32'd0);
        run_dump(3'd0, 3'd7, 0, -1);
        check_dump("post-reset dump", 3'd0, 3'd7, 8, 16'h1000, 16'h1007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
